// File: rtl/pzbcm_onehot_collector_if.sv
// Index stream in (valid/ready + last) and registered bitmap result out (valid/ready).
// slave is the collector side; master is the producer/consumer side.
interface pzbcm_onehot_collector_if #(
    parameter int N = 1
);
    localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1;
    localparam int COUNT_WIDTH  = $clog2(N + 1);

    logic                    i_valid;
    logic                    o_ready;
    logic [BINARY_WIDTH-1:0] i_index;
    logic                    i_last;
    logic                    o_valid;
    logic                    i_ready;
    logic [N-1:0]            o_bits;
    logic [COUNT_WIDTH-1:0]  o_count;
    logic                    o_range_error;
    logic                    o_duplicate;

    modport slave (
        input  i_valid, i_index, i_last, i_ready,
        output o_ready, o_valid, o_bits, o_count, o_range_error, o_duplicate
    );

    modport master (
        output i_valid, i_index, i_last, i_ready,
        input  o_ready, o_valid, o_bits, o_count, o_range_error, o_duplicate
    );
endinterface

// File: rtl/pzbcm_onehot_collector.sv
// ORs a frame of binary indices into an N-bit bitmap; result registered 1 cycle after the last beat.
// Backpressure: o_ready = !o_valid || i_ready, so a stalled result stalls every input beat.
module pzbcm_onehot_collector #(
    parameter int N = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    pzbcm_onehot_collector_if.slave   bus
);
    localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1;
    localparam int COUNT_WIDTH  = $clog2(N + 1);
    localparam logic [BINARY_WIDTH:0] N_LIMIT = (BINARY_WIDTH + 1)'(N);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                  state_q;
    logic [N-1:0]            acc_bits_q;
    logic [COUNT_WIDTH-1:0]  acc_count_q;
    logic                    acc_range_error_q;
    logic                    acc_duplicate_q;

    logic                    out_valid_q;
    logic [N-1:0]            out_bits_q;
    logic [COUNT_WIDTH-1:0]  out_count_q;
    logic                    out_range_error_q;
    logic                    out_duplicate_q;

    logic                    ready;
    logic                    accept;
    logic                    in_range;
    logic [N-1:0]            onehot;
    logic [N-1:0]            base_bits;
    logic                    hit;
    logic [N-1:0]            acc_bits_d;
    logic [COUNT_WIDTH-1:0]  acc_count_d;
    logic                    acc_range_error_d;
    logic                    acc_duplicate_d;

    assign ready  = !out_valid_q || bus.i_ready;
    assign accept = bus.i_valid && ready;

    // Accumulator with the current beat applied; IDLE means the accumulator is empty.
    always_comb begin
        in_range          = {1'b0, bus.i_index} < N_LIMIT;
        onehot            = in_range ? (N'(1) << bus.i_index) : '0;
        base_bits         = (state_q == IDLE) ? '0 : acc_bits_q;
        hit               = |(base_bits & onehot);
        acc_bits_d        = base_bits | onehot;
        acc_count_d       = ((state_q == IDLE) ? '0 : acc_count_q)
                          + COUNT_WIDTH'(in_range && !hit);
        acc_range_error_d = ((state_q == IDLE) ? 1'b0 : acc_range_error_q) | !in_range;
        acc_duplicate_d   = ((state_q == IDLE) ? 1'b0 : acc_duplicate_q) | hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= IDLE;
            acc_bits_q        <= '0;
            acc_count_q       <= '0;
            acc_range_error_q <= 1'b0;
            acc_duplicate_q   <= 1'b0;
            out_valid_q       <= 1'b0;
            out_bits_q        <= '0;
            out_count_q       <= '0;
            out_range_error_q <= 1'b0;
            out_duplicate_q   <= 1'b0;
        end else begin
            if (accept && bus.i_last) begin
                out_valid_q       <= 1'b1;
                out_bits_q        <= acc_bits_d;
                out_count_q       <= acc_count_d;
                out_range_error_q <= acc_range_error_d;
                out_duplicate_q   <= acc_duplicate_d;
            end else if (out_valid_q && bus.i_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                case (state_q)
                    IDLE, BUSY: begin
                        if (bus.i_last) begin
                            state_q           <= IDLE;
                            acc_bits_q        <= '0;
                            acc_count_q       <= '0;
                            acc_range_error_q <= 1'b0;
                            acc_duplicate_q   <= 1'b0;
                        end else begin
                            state_q           <= BUSY;
                            acc_bits_q        <= acc_bits_d;
                            acc_count_q       <= acc_count_d;
                            acc_range_error_q <= acc_range_error_d;
                            acc_duplicate_q   <= acc_duplicate_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = out_valid_q;
    assign bus.o_bits        = out_bits_q;
    assign bus.o_count       = out_count_q;
    assign bus.o_range_error = out_range_error_q;
    assign bus.o_duplicate   = out_duplicate_q;
endmodule

// File: tb/tb_pzbcm_onehot_collector.sv
// Bench for pzbcm_onehot_collector: three instances (N=8, N=5, N=16) driven by directed frames,
// checked every cycle against a frame-level model and at key points against literal results.
module tb_pzbcm_onehot_collector;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       drv_valid [NI];
    logic       drv_last  [NI];
    logic       drv_ready [NI];
    logic [3:0] drv_index [NI];

    logic        dut_valid [NI];
    logic        dut_ready [NI];
    logic        dut_rerr  [NI];
    logic        dut_dup   [NI];
    logic [15:0] dut_bits  [NI];
    logic [4:0]  dut_count [NI];

    pzbcm_onehot_collector_if #(.N(8))  if0 ();
    pzbcm_onehot_collector_if #(.N(5))  if1 ();
    pzbcm_onehot_collector_if #(.N(16)) if2 ();

    pzbcm_onehot_collector #(.N(8))  u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    pzbcm_onehot_collector #(.N(5))  u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    pzbcm_onehot_collector #(.N(16)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    assign if0.i_valid = drv_valid[0];
    assign if0.i_last  = drv_last[0];
    assign if0.i_ready = drv_ready[0];
    assign if0.i_index = drv_index[0][2:0];
    assign if1.i_valid = drv_valid[1];
    assign if1.i_last  = drv_last[1];
    assign if1.i_ready = drv_ready[1];
    assign if1.i_index = drv_index[1][2:0];
    assign if2.i_valid = drv_valid[2];
    assign if2.i_last  = drv_last[2];
    assign if2.i_ready = drv_ready[2];
    assign if2.i_index = drv_index[2];

    assign dut_valid[0] = if0.o_valid;
    assign dut_ready[0] = if0.o_ready;
    assign dut_rerr[0]  = if0.o_range_error;
    assign dut_dup[0]   = if0.o_duplicate;
    assign dut_bits[0]  = 16'(if0.o_bits);
    assign dut_count[0] = 5'(if0.o_count);
    assign dut_valid[1] = if1.o_valid;
    assign dut_ready[1] = if1.o_ready;
    assign dut_rerr[1]  = if1.o_range_error;
    assign dut_dup[1]   = if1.o_duplicate;
    assign dut_bits[1]  = 16'(if1.o_bits);
    assign dut_count[1] = 5'(if1.o_count);
    assign dut_valid[2] = if2.o_valid;
    assign dut_ready[2] = if2.o_ready;
    assign dut_rerr[2]  = if2.o_range_error;
    assign dut_dup[2]   = if2.o_duplicate;
    assign dut_bits[2]  = 16'(if2.o_bits);
    assign dut_count[2] = 5'(if2.o_count);

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    function automatic int nval(input int i);
        return (i == 0) ? 8 : (i == 1) ? 5 : 16;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // Frame-level model: remember the frame's indices, derive the result when the last beat lands.
    int          frame_q [NI][$];
    logic        m_valid [NI];
    logic [15:0] m_bits  [NI];
    logic [4:0]  m_count [NI];
    logic        m_rerr  [NI];
    logic        m_dup   [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            automatic logic        acc;
            automatic logic [15:0] b;
            automatic logic        r;
            automatic logic        d;
            automatic int          x;
            if (rst) begin
                frame_q[i].delete();
                m_valid[i] <= 1'b0;
            end else begin
                acc = drv_valid[i] && (!m_valid[i] || drv_ready[i]);
                if (acc) frame_q[i].push_back(int'(drv_index[i]));
                if (acc && drv_last[i]) begin
                    b = '0; r = 1'b0; d = 1'b0;
                    for (int k = 0; k < frame_q[i].size(); k++) begin
                        x = frame_q[i][k];
                        if (x >= nval(i)) r = 1'b1;
                        else begin
                            for (int j = 0; j < k; j++)
                                if (frame_q[i][j] == x) d = 1'b1;
                            b = b | (16'(1) << x);
                        end
                    end
                    frame_q[i].delete();
                    m_valid[i] <= 1'b1;
                    m_bits[i]  <= b;
                    m_count[i] <= 5'($countones(b));
                    m_rerr[i]  <= r;
                    m_dup[i]   <= d;
                end else if (m_valid[i] && drv_ready[i]) begin
                    m_valid[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("mdl_valid", i, 32'(dut_valid[i]), 32'(m_valid[i]));
                chk("mdl_ready", i, 32'(dut_ready[i]), 32'(!m_valid[i] || drv_ready[i]));
                if (m_valid[i]) begin
                    chk("mdl_bits",  i, 32'(dut_bits[i]),  32'(m_bits[i]));
                    chk("mdl_count", i, 32'(dut_count[i]), 32'(m_count[i]));
                    chk("mdl_rerr",  i, 32'(dut_rerr[i]),  32'(m_rerr[i]));
                    chk("mdl_dup",   i, 32'(dut_dup[i]),   32'(m_dup[i]));
                end
            end
        end
    end

    // Called at posedge+#1; holds the beat until an edge where o_ready was high.
    task automatic beat(input int i, input int idx, input logic last);
        int n;
        drv_valid[i] = 1'b1;
        drv_index[i] = 4'(idx);
        drv_last[i]  = last;
        n = 0;
        @(negedge clk);
        while (!dut_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("beat_timeout", i, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        drv_valid[i] = 1'b0;
    endtask

    task automatic lit(input int i, input logic [15:0] bits, input int cnt, input logic rerr, input logic dup);
        chk("lit_valid", i, 32'(dut_valid[i]), 32'd1);
        chk("lit_bits",  i, 32'(dut_bits[i]),  32'(bits));
        chk("lit_count", i, 32'(dut_count[i]), 32'(cnt));
        chk("lit_rerr",  i, 32'(dut_rerr[i]),  32'(rerr));
        chk("lit_dup",   i, 32'(dut_dup[i]),   32'(dup));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            drv_valid[i] = 1'b0;
            drv_last[i]  = 1'b0;
            drv_ready[i] = 1'b1;
            drv_index[i] = 4'd0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 0, 32'(dut_valid[0]), 32'd0);
        chk("rst_bits",  0, 32'(dut_bits[0]),  32'd0);
        chk("rst_count", 0, 32'(dut_count[0]), 32'd0);
        chk("rst_flags", 0, 32'({dut_rerr[0], dut_dup[0]}), 32'd0);
        chk("rst_ready", 0, 32'(dut_ready[0]), 32'd1);
        rst = 1'b0;
        chk_en = 1'b1;

        beat(0, 3, 1'b0); beat(0, 5, 1'b0); beat(0, 0, 1'b1);
        lit(0, 16'h0029, 3, 1'b0, 1'b0);

        beat(0, 2, 1'b0); beat(0, 2, 1'b0); beat(0, 7, 1'b1);
        lit(0, 16'h0084, 2, 1'b0, 1'b1);
        beat(0, 1, 1'b1);
        lit(0, 16'h0002, 1, 1'b0, 1'b0);

        beat(1, 6, 1'b0); beat(1, 4, 1'b1);
        lit(1, 16'h0010, 1, 1'b1, 1'b0);
        beat(1, 7, 1'b1);
        lit(1, 16'h0000, 0, 1'b1, 1'b0);

        // Result stalled for three cycles while the next frame waits.
        drv_ready[0] = 1'b0;
        beat(0, 1, 1'b1);
        lit(0, 16'h0002, 1, 1'b0, 1'b0);
        drv_valid[0] = 1'b1;
        drv_index[0] = 4'd0;
        drv_last[0]  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready", 0, 32'(dut_ready[0]), 32'd0);
            chk("bp_bits",  0, 32'(dut_bits[0]),  32'h02);
        end
        #1;
        drv_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        drv_valid[0] = 1'b0;
        lit(0, 16'h0001, 1, 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            beat(2, k, 1'b1);
            lit(2, 16'(1) << k, 1, 1'b0, 1'b0);
            chk("stream_ready", 2, 32'(dut_ready[2]), 32'd1);
        end

        beat(0, 4, 1'b0); beat(0, 6, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_valid", 0, 32'(dut_valid[0]), 32'd0);
        beat(0, 0, 1'b1);
        lit(0, 16'h0001, 1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
